spike_dispatcher: RTL and testbench

//  Reader end of the fire FIFO. Pops one fired-neuron tag at a time, looks up

---
 rtl/spike_dispatcher.sv | 134 +++++++++++++
 tb/tb_spike_dispatcher.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_dispatcher.sv
// spike_dispatcher
//   Reader end of the fire FIFO. Pops one fired-neuron tag at a time, reads
//   that neuron's fan-out row (edge base, edge count) from the row table, then
//   walks the edge table and emits one (target, weight) synaptic event per edge
//   on a valid/ready stream toward the neuron update stage.
//
// Ports
//   clk, asyn_reset          clock (rising edge), asynchronous active-high reset
//   fifo_empty, fifo_tag     fire FIFO status and head tag
//   fifo_deq                 pop request, one-cycle pulse
//   row_addr                 row table read address (synchronous RAM)
//   row_base, row_len        row table data, valid the cycle after row_addr
//   edge_addr                edge table read address (synchronous RAM)
//   edge_target, edge_weight edge table data, valid the cycle after edge_addr
//   syn_valid, syn_ready     synaptic event handshake
//   syn_target, syn_weight   synaptic event payload, held until accepted
//   busy                     high whenever the walker is not idle
//   done                     one-cycle pulse when a tag's fan-out completes
module spike_dispatcher #(
  parameter int unsigned numneurons   = 2,
  parameter int unsigned tagbits      = 1,
  parameter int unsigned edgeaddrbits = 4,
  parameter int unsigned lenbits      = 3,
  parameter int unsigned weightbits   = 8
) (
  input  logic                    clk,
  input  logic                    asyn_reset,
  input  logic                    fifo_empty,
  input  logic [tagbits-1:0]      fifo_tag,
  output logic                    fifo_deq,
  output logic [tagbits-1:0]      row_addr,
  input  logic [edgeaddrbits-1:0] row_base,
  input  logic [lenbits-1:0]      row_len,
  output logic [edgeaddrbits-1:0] edge_addr,
  input  logic [tagbits-1:0]      edge_target,
  input  logic [weightbits-1:0]   edge_weight,
  output logic                    syn_valid,
  input  logic                    syn_ready,
  output logic [tagbits-1:0]      syn_target,
  output logic [weightbits-1:0]   syn_weight,
  output logic                    busy,
  output logic                    done
);

  // A neuron count that the tag width cannot address leaves this named
  // block visible in the elaborated hierarchy.
  if (numneurons > (1 << tagbits)) begin : g_tagbits_too_narrow_for_numneurons
  end

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    ROW_RD,
    EDGE,
    EDGE_RD,
    SEND
  } state_t;

  state_t                  state;
  logic [edgeaddrbits-1:0] base_r;
  logic [lenbits-1:0]      len_r;
  logic [lenbits-1:0]      idx;
  logic [lenbits:0]        idx_inc;
  logic                    accept;
  logic                    last_edge;

  // One extra bit so a full-length row (2^lenbits-1 edges) still matches.
  assign idx_inc   = {1'b0, idx} + {{lenbits{1'b0}}, 1'b1};
  assign last_edge = (idx_inc == {1'b0, len_r});
  assign accept    = (state == SEND) && syn_ready;

  // fifo_deq and done react within the cycle (a zero-length row is only known
  // once row_len arrives); the reset term keeps the pop quiet while in reset.
  assign fifo_deq  = !asyn_reset && (state == IDLE) && !fifo_empty;
  assign done      = ((state == ROW_RD) && (row_len == '0)) || (accept && last_edge);
  assign busy      = (state != IDLE);
  assign syn_valid = (state == SEND);

  // row_addr doubles as the latched tag register; it is loaded on the pop and
  // held while the row read is in flight.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state      <= IDLE;
      row_addr   <= '0;
      edge_addr  <= '0;
      base_r     <= '0;
      len_r      <= '0;
      idx        <= '0;
      syn_target <= '0;
      syn_weight <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            row_addr <= fifo_tag;
            state    <= ROW;
          end
        end
        ROW: begin
          state <= ROW_RD;
        end
        ROW_RD: begin
          base_r    <= row_base;
          len_r     <= row_len;
          idx       <= '0;
          // First edge address comes straight from the row data so the edge
          // read can start in the very next cycle.
          edge_addr <= row_base;
          state     <= (row_len == '0) ? IDLE : EDGE;
        end
        EDGE: begin
          state <= EDGE_RD;
        end
        EDGE_RD: begin
          syn_target <= edge_target;
          syn_weight <= edge_weight;
          state      <= SEND;
        end
        SEND: begin
          if (syn_ready) begin
            idx       <= idx_inc[lenbits-1:0];
            // Truncation to the address width gives the wrap past the top.
            edge_addr <= base_r + edgeaddrbits'(idx_inc);
            state     <= last_edge ? IDLE : EDGE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_dispatcher.sv
// Testbench for spike_dispatcher: behavioural fire FIFO, synchronous row and
// edge tables, and a scoreboard of expected synaptic events filled when tags
// are pushed and drained as the DUT hands events over.
module tb_spike_dispatcher;
  localparam int TB = 1;
  localparam int EB = 4;
  localparam int LB = 3;
  localparam int WB = 8;

  logic          clk = 1'b0;
  logic          asyn_reset;
  logic          fifo_empty;
  logic [TB-1:0] fifo_tag;
  logic          fifo_deq;
  logic [TB-1:0] row_addr;
  logic [EB-1:0] row_base;
  logic [LB-1:0] row_len;
  logic [EB-1:0] edge_addr;
  logic [TB-1:0] edge_target;
  logic [WB-1:0] edge_weight;
  logic          syn_valid;
  logic          syn_ready;
  logic [TB-1:0] syn_target;
  logic [WB-1:0] syn_weight;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  spike_dispatcher #(
    .numneurons(2), .tagbits(TB), .edgeaddrbits(EB), .lenbits(LB), .weightbits(WB)
  ) dut (
    .clk(clk), .asyn_reset(asyn_reset), .fifo_empty(fifo_empty), .fifo_tag(fifo_tag),
    .fifo_deq(fifo_deq), .row_addr(row_addr), .row_base(row_base), .row_len(row_len),
    .edge_addr(edge_addr), .edge_target(edge_target), .edge_weight(edge_weight),
    .syn_valid(syn_valid), .syn_ready(syn_ready), .syn_target(syn_target),
    .syn_weight(syn_weight), .busy(busy), .done(done)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct packed {
    logic [TB-1:0] target;
    logic [WB-1:0] weight;
  } ev_t;
  ev_t sb[$];

  // Fire FIFO model
  logic [TB-1:0] fifo_mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_tag   = fifo_mem[rd_ptr % 16];
  always @(posedge clk) if (fifo_deq) rd_ptr <= rd_ptr + 1;

  // Synchronous table models
  logic [EB-1:0] row_base_mem [2];
  logic [LB-1:0] row_len_mem  [2];
  logic [TB-1:0] edge_tgt_mem [16];
  logic [WB-1:0] edge_wt_mem  [16];
  always @(posedge clk) begin
    row_base    <= row_base_mem[row_addr];
    row_len     <= row_len_mem[row_addr];
    edge_target <= edge_tgt_mem[edge_addr];
    edge_weight <= edge_wt_mem[edge_addr];
  end

  task automatic push_tag(input logic [TB-1:0] t);
    ev_t e;
    fifo_mem[wr_ptr % 16] = t;
    wr_ptr = wr_ptr + 1;
    for (int i = 0; i < int'(row_len_mem[t]); i++) begin
      e.target = edge_tgt_mem[(int'(row_base_mem[t]) + i) % 16];
      e.weight = edge_wt_mem[(int'(row_base_mem[t]) + i) % 16];
      sb.push_back(e);
    end
  endtask

  task automatic load_tag1_row();
    row_base_mem[1] = 4'd4;  row_len_mem[1] = 3'd3;
    edge_tgt_mem[4] = 1'b0;  edge_wt_mem[4] = 8'sd5;
    edge_tgt_mem[5] = 1'b1;  edge_wt_mem[5] = 8'hFD;
    edge_tgt_mem[6] = 1'b0;  edge_wt_mem[6] = 8'sd127;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    asyn_reset = 1'b1;
    syn_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({fifo_deq, busy, done, syn_valid, syn_target, syn_weight, row_addr, edge_addr} !== '0)
      $display("FAIL reset_state got deq=%b busy=%b done=%b vld=%b tgt=%h wt=%h ra=%h ea=%h want all 0",
               fifo_deq, busy, done, syn_valid, syn_target, syn_weight, row_addr, edge_addr);
    else pass_cnt++;
    asyn_reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      got = {fifo_deq, busy, syn_valid, done};
      chk_cnt++;
      if (got !== 4'b0000) $display("FAIL empty_idle cyc %0d got deq/busy/vld/done=%b want 0000", k, got);
      else pass_cnt++;
    end
  endtask

  task automatic test_single_tag();
    logic [3:0] got, exp;
    load_tag1_row();
    syn_ready = 1'b1;
    @(negedge clk);
    push_tag(1'b1);
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      got = {syn_valid, done, fifo_deq, busy};
      exp = {(k == 5 || k == 8 || k == 11), (k == 11), (k == 0), (k >= 1 && k <= 11)};
      chk_cnt++;
      if (got !== exp) $display("FAIL single_ctrl cyc %0d got vld/done/deq/busy=%b want %b", k, got, exp);
      else pass_cnt++;
      if (syn_valid) begin
        chk_cnt++;
        if (sb.size() == 0) $display("FAIL single_event cyc %0d got tgt=%h wt=%h want no event", k, syn_target, syn_weight);
        else if ({syn_target, syn_weight} !== sb[0]) $display("FAIL single_event cyc %0d got %h want %h", k, {syn_target, syn_weight}, sb[0]);
        else pass_cnt++;
        if (syn_ready && sb.size() != 0) void'(sb.pop_front());
      end
    end
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL single_drain got %0d pending want 0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [3:0] got, exp;
    load_tag1_row();
    @(negedge clk);
    push_tag(1'b1);
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) @(negedge clk);
      syn_ready = !(k >= 8 && k <= 11);
      #1;
      got = {syn_valid, done, fifo_deq, busy};
      exp = {(k == 5 || (k >= 8 && k <= 12) || k == 15), (k == 15), (k == 0), (k >= 1 && k <= 15)};
      chk_cnt++;
      if (got !== exp) $display("FAIL bp_ctrl cyc %0d got vld/done/deq/busy=%b want %b", k, got, exp);
      else pass_cnt++;
      if (syn_valid) begin
        chk_cnt++;
        if (sb.size() == 0) $display("FAIL bp_event cyc %0d got tgt=%h wt=%h want no event", k, syn_target, syn_weight);
        else if ({syn_target, syn_weight} !== sb[0]) $display("FAIL bp_event cyc %0d got %h want %h", k, {syn_target, syn_weight}, sb[0]);
        else pass_cnt++;
        if (syn_ready && sb.size() != 0) void'(sb.pop_front());
      end
    end
    syn_ready = 1'b1;
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL bp_drain got %0d pending want 0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [3:0]    got, exp;
    logic [EB-1:0] exp_ea;
    row_base_mem[0] = 4'd14; row_len_mem[0] = 3'd3;
    edge_tgt_mem[14] = 1'b1; edge_wt_mem[14] = 8'h11;
    edge_tgt_mem[15] = 1'b0; edge_wt_mem[15] = 8'h80;
    edge_tgt_mem[0]  = 1'b1; edge_wt_mem[0]  = 8'h01;
    syn_ready = 1'b1;
    @(negedge clk);
    push_tag(1'b0);
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      got = {syn_valid, done, fifo_deq, busy};
      exp = {(k == 5 || k == 8 || k == 11), (k == 11), (k == 0), (k >= 1 && k <= 11)};
      chk_cnt++;
      if (got !== exp) $display("FAIL wrap_ctrl cyc %0d got vld/done/deq/busy=%b want %b", k, got, exp);
      else pass_cnt++;
      if (k == 3 || k == 6 || k == 9) begin
        exp_ea = (k == 3) ? 4'd14 : (k == 6) ? 4'd15 : 4'd0;
        chk_cnt++;
        if (edge_addr !== exp_ea) $display("FAIL wrap_edge_addr cyc %0d got %0d want %0d", k, edge_addr, exp_ea);
        else pass_cnt++;
      end
      if (syn_valid) begin
        chk_cnt++;
        if (sb.size() == 0) $display("FAIL wrap_event cyc %0d got tgt=%h wt=%h want no event", k, syn_target, syn_weight);
        else if ({syn_target, syn_weight} !== sb[0]) $display("FAIL wrap_event cyc %0d got %h want %h", k, {syn_target, syn_weight}, sb[0]);
        else pass_cnt++;
        if (syn_ready && sb.size() != 0) void'(sb.pop_front());
      end
    end
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL wrap_drain got %0d pending want 0", sb.size());
    else pass_cnt++;
  endtask

  // Zero-length row followed immediately by a normal row (back-to-back pops).
  task automatic test_len_zero_back_to_back();
    logic [3:0] got, exp;
    row_base_mem[0] = 4'd2; row_len_mem[0] = 3'd0;
    load_tag1_row();
    syn_ready = 1'b1;
    @(negedge clk);
    push_tag(1'b0);
    push_tag(1'b1);
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      got = {syn_valid, done, fifo_deq, busy};
      exp = {(k == 8 || k == 11 || k == 14), (k == 2 || k == 14), (k == 0 || k == 3),
             ((k >= 1 && k <= 2) || (k >= 4 && k <= 14))};
      chk_cnt++;
      if (got !== exp) $display("FAIL len0_ctrl cyc %0d got vld/done/deq/busy=%b want %b", k, got, exp);
      else pass_cnt++;
      if (syn_valid) begin
        chk_cnt++;
        if (sb.size() == 0) $display("FAIL len0_event cyc %0d got tgt=%h wt=%h want no event", k, syn_target, syn_weight);
        else if ({syn_target, syn_weight} !== sb[0]) $display("FAIL len0_event cyc %0d got %h want %h", k, {syn_target, syn_weight}, sb[0]);
        else pass_cnt++;
        if (syn_ready && sb.size() != 0) void'(sb.pop_front());
      end
    end
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL len0_drain got %0d pending want 0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_send();
    logic [3:0] got, exp;
    load_tag1_row();
    syn_ready = 1'b0;
    @(negedge clk);
    push_tag(1'b1);
    push_tag(1'b1);
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      got = {syn_valid, fifo_deq};
      exp = {(k >= 5), (k == 0)};
      chk_cnt++;
      if (got[1:0] !== exp[1:0]) $display("FAIL rst_mid_pre cyc %0d got vld/deq=%b want %b", k, got[1:0], exp[1:0]);
      else pass_cnt++;
    end
    // Mid-cycle reset, checked before the next clock edge.
    #2 asyn_reset = 1'b1;
    #1;
    chk_cnt++;
    if ({fifo_deq, busy, done, syn_valid, syn_target, syn_weight, row_addr, edge_addr} !== '0)
      $display("FAIL rst_mid_async got deq=%b busy=%b done=%b vld=%b tgt=%h wt=%h ra=%h ea=%h want all 0",
               fifo_deq, busy, done, syn_valid, syn_target, syn_weight, row_addr, edge_addr);
    else pass_cnt++;
    repeat (3) void'(sb.pop_front());
    @(negedge clk);
    chk_cnt++;
    if ({fifo_deq, busy, syn_valid} !== 3'b000) $display("FAIL rst_mid_held got deq/busy/vld=%b want 000", {fifo_deq, busy, syn_valid});
    else pass_cnt++;
    asyn_reset = 1'b0;
    syn_ready  = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      got = {syn_valid, done, fifo_deq, busy};
      exp = {(k == 5 || k == 8 || k == 11), (k == 11), (k == 0), (k >= 1 && k <= 11)};
      chk_cnt++;
      if (got !== exp) $display("FAIL rst_mid_restart cyc %0d got vld/done/deq/busy=%b want %b", k, got, exp);
      else pass_cnt++;
      if (syn_valid) begin
        chk_cnt++;
        if (sb.size() == 0) $display("FAIL rst_mid_event cyc %0d got tgt=%h wt=%h want no event", k, syn_target, syn_weight);
        else if ({syn_target, syn_weight} !== sb[0]) $display("FAIL rst_mid_event cyc %0d got %h want %h", k, {syn_target, syn_weight}, sb[0]);
        else pass_cnt++;
        if (syn_ready && sb.size() != 0) void'(sb.pop_front());
      end
    end
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL rst_mid_drain got %0d pending want 0", sb.size());
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      fifo_mem[i] = '0; edge_tgt_mem[i] = '0; edge_wt_mem[i] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      row_base_mem[i] = '0; row_len_mem[i] = '0;
    end
    test_reset();
    test_single_tag();
    test_backpressure();
    test_wrap();
    test_len_zero_back_to_back();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
